// File: rtl/rf_pkg.sv
// Shared register-file writeback types and constants.
// Widths, the hard-wired zero register, and the arbiter grant encoding.
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters, the hazard unit and the RF write port.
// The slave modport is the arbiter's view; master is everyone else.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH    = REG_DATA_W
);
    logic                     hold;
    logic                     req0_valid;
    logic [ADDRESS_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0]    req0_data;
    logic                     req0_ready;
    logic                     req1_valid;
    logic [ADDRESS_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0]    req1_data;
    logic                     req1_ready;
    logic                     we3;
    logic [ADDRESS_WIDTH-1:0] a3;
    logic [DATA_WIDTH-1:0]    wd3;
    logic [ADDRESS_WIDTH-1:0] q_a1;
    logic [ADDRESS_WIDTH-1:0] q_a2;
    logic                     busy1;
    logic                     busy2;

    modport slave (
        input  hold,
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  q_a1, q_a2,
        output req0_ready, req1_ready,
        output we3, a3, wd3,
        output busy1, busy2
    );

    modport master (
        output hold,
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output q_a1, q_a2,
        input  req0_ready, req1_ready,
        input  we3, a3, wd3,
        input  busy1, busy2
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grant is combinational from valids and last winner.
// i_advance must be asserted only in cycles where a grant is actually taken.
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant
);
    grant_e r_last_grant;

    always_comb begin
        o_grant    = 2'b00;
        o_grant[0] = i_valid[0] && (!i_valid[1] || (r_last_grant == GRANT_REQ1));
        o_grant[1] = i_valid[1] && (!i_valid[0] || (r_last_grant == GRANT_REQ0));
    end

    // Reset to REQ1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_REQ1;
        end else if (i_advance) begin
            r_last_grant <= o_grant[1] ? GRANT_REQ1 : GRANT_REQ0;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline and load writebacks.
// One-cycle registered write stage; busy flags compare query addresses with it.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH    = REG_DATA_W
)(
    input  logic            clk,
    input  logic            rst_n,
    rf_wb_arbiter_if.slave  bus
);
    logic [1:0]               w_valid;
    logic [1:0]               w_grant;
    logic                     w_xfer;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_data;
    logic                     w_commit;

    logic                     r_we3;
    logic [ADDRESS_WIDTH-1:0] r_a3;
    logic [DATA_WIDTH-1:0]    r_wd3;

    // Masking the valids with hold keeps both readies low and freezes last_grant.
    assign w_valid = {bus.req1_valid, bus.req0_valid} & {2{~bus.hold}};

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (w_valid),
        .i_advance (w_xfer),
        .o_grant   (w_grant)
    );

    assign w_xfer   = |w_grant;
    assign w_addr   = w_grant[1] ? bus.req1_addr : bus.req0_addr;
    assign w_data   = w_grant[1] ? bus.req1_data : bus.req0_data;
    assign w_commit = w_xfer && (w_addr != ADDRESS_WIDTH'(REG_ZERO));

    // Writes to x0 are accepted but dropped; a3/wd3 keep their last real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_commit;
            if (w_commit) begin
                r_a3  <= w_addr;
                r_wd3 <= w_data;
            end
        end
    end

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];
    assign bus.we3        = r_we3;
    assign bus.a3         = r_a3;
    assign bus.wd3        = r_wd3;
    assign bus.busy1      = r_we3 && (bus.q_a1 == r_a3);
    assign bus.busy2      = r_we3 && (bus.q_a2 == r_a3);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single writes, contention, x0/hold, async reset.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    rf_wb_arbiter_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

    rf_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.hold       = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        bus.q_a1       = '0;
        bus.q_a2       = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req0(input wb_req_t r);
        bus.req0_valid = 1'b1;
        bus.req0_addr  = r.addr;
        bus.req0_data  = r.data;
    endtask

    task automatic set_req1(input wb_req_t r);
        bus.req1_valid = 1'b1;
        bus.req1_addr  = r.addr;
        bus.req1_data  = r.data;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.we3 !== 1'b0) begin n_errors++; $display("FAIL reset_we3: got %0b want 0", bus.we3); end
        n_checks++; if (bus.a3 !== 5'd0) begin n_errors++; $display("FAIL reset_a3: got %0d want 0", bus.a3); end
        n_checks++; if (bus.wd3 !== 32'd0) begin n_errors++; $display("FAIL reset_wd3: got %h want 0", bus.wd3); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus.we3, bus.a3, bus.wd3, bus.busy1, bus.busy2} !== 40'd0) begin
                n_errors++;
                $display("FAIL idle_outputs cycle %0d: we3=%0b a3=%0d wd3=%h busy=%0b%0b want all 0",
                         i, bus.we3, bus.a3, bus.wd3, bus.busy1, bus.busy2);
            end
            n_checks++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                n_errors++; $display("FAIL idle_ready cycle %0d: got %b want 00", i, {bus.req0_ready, bus.req1_ready});
            end
        end
    endtask

    task automatic test_single();
        set_req0('{addr: 5'd5, data: 32'hDEADBEEF});
        bus.q_a1 = 5'd5;
        bus.q_a2 = 5'd6;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready0: got %0b want 1", bus.req0_ready); end
        n_checks++; if (bus.req1_ready !== 1'b0) begin n_errors++; $display("FAIL single_ready1: got %0b want 0", bus.req1_ready); end
        n_checks++; if (bus.busy1 !== 1'b0) begin n_errors++; $display("FAIL single_busy1_before: got %0b want 0", bus.busy1); end
        tick();
        bus.req0_valid = 1'b0;
        n_checks++; if (bus.we3 !== 1'b1) begin n_errors++; $display("FAIL single_we3: got %0b want 1", bus.we3); end
        n_checks++; if (bus.a3 !== 5'd5) begin n_errors++; $display("FAIL single_a3: got %0d want 5", bus.a3); end
        n_checks++; if (bus.wd3 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_wd3: got %h want deadbeef", bus.wd3); end
        n_checks++; if (bus.busy1 !== 1'b1) begin n_errors++; $display("FAIL single_busy1: got %0b want 1", bus.busy1); end
        n_checks++; if (bus.busy2 !== 1'b0) begin n_errors++; $display("FAIL single_busy2: got %0b want 0", bus.busy2); end
        tick();
        n_checks++; if (bus.we3 !== 1'b0) begin n_errors++; $display("FAIL single_we3_after: got %0b want 0", bus.we3); end
        n_checks++; if (bus.busy1 !== 1'b0) begin n_errors++; $display("FAIL single_busy1_after: got %0b want 0", bus.busy1); end
        n_checks++; if (bus.a3 !== 5'd5) begin n_errors++; $display("FAIL single_a3_hold: got %0d want 5", bus.a3); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        do_reset();
        set_req0('{addr: 5'd1, data: 32'h0000_0011});
        set_req1('{addr: 5'd2, data: 32'h0000_0022});
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({bus.req1_ready, bus.req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_errors++;
                $display("FAIL contention_grant cycle %0d: ready1/0=%b want %b",
                         i, {bus.req1_ready, bus.req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            n_checks++;
            if (bus.req0_ready && bus.req1_ready) begin
                n_errors++; $display("FAIL contention_both_ready cycle %0d: got 11 want one-hot", i);
            end
            if (i > 0) begin
                exp_a = (i % 2 == 1) ? 5'd1 : 5'd2;
                exp_d = (i % 2 == 1) ? 32'h11 : 32'h22;
                n_checks++;
                if ({bus.we3, bus.a3, bus.wd3} !== {1'b1, exp_a, exp_d}) begin
                    n_errors++;
                    $display("FAIL contention_write cycle %0d: we3=%0b a3=%0d wd3=%h want 1 %0d %h",
                             i, bus.we3, bus.a3, bus.wd3, exp_a, exp_d);
                end
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n_checks++;
        if ({bus.we3, bus.a3, bus.wd3} !== {1'b1, 5'd2, 32'h22}) begin
            n_errors++;
            $display("FAIL contention_last_write: we3=%0b a3=%0d wd3=%h want 1 2 00000022", bus.we3, bus.a3, bus.wd3);
        end
        tick();
        n_checks++; if (bus.we3 !== 1'b0) begin n_errors++; $display("FAIL contention_drain: we3=%0b want 0", bus.we3); end
    endtask

    task automatic test_x0_hold();
        idle_inputs();
        set_req1('{addr: 5'd0, data: 32'h0000_1234});
        bus.q_a1 = 5'd0;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1) begin n_errors++; $display("FAIL x0_ready: got %0b want 1", bus.req1_ready); end
        tick();
        bus.req1_valid = 1'b0;
        n_checks++; if (bus.we3 !== 1'b0) begin n_errors++; $display("FAIL x0_we3: got %0b want 0", bus.we3); end
        n_checks++; if (bus.busy1 !== 1'b0) begin n_errors++; $display("FAIL x0_busy1: got %0b want 0", bus.busy1); end

        set_req0('{addr: 5'd7, data: 32'h0000_0077});
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_errors++; $display("FAIL hold_pre_ready0: got %0b want 1", bus.req0_ready); end
        tick();
        bus.hold = 1'b1;
        set_req0('{addr: 5'd3, data: 32'h0000_0033});
        set_req1('{addr: 5'd9, data: 32'h0000_0099});
        #1;
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            n_errors++; $display("FAIL hold_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
        end
        n_checks++;
        if ({bus.we3, bus.a3, bus.wd3} !== {1'b1, 5'd7, 32'h77}) begin
            n_errors++; $display("FAIL hold_inflight: we3=%0b a3=%0d wd3=%h want 1 7 00000077", bus.we3, bus.a3, bus.wd3);
        end
        tick();
        n_checks++; if (bus.we3 !== 1'b0) begin n_errors++; $display("FAIL hold_we3: got %0b want 0", bus.we3); end
        bus.hold = 1'b0;
        #1;
        n_checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            n_errors++; $display("FAIL hold_release_grant: ready1/0=%b want 10", {bus.req1_ready, bus.req0_ready});
        end
        tick();
        bus.req1_valid = 1'b0;
        n_checks++;
        if ({bus.we3, bus.a3, bus.wd3} !== {1'b1, 5'd9, 32'h99}) begin
            n_errors++; $display("FAIL hold_release_write: we3=%0b a3=%0d wd3=%h want 1 9 00000099", bus.we3, bus.a3, bus.wd3);
        end
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_errors++; $display("FAIL hold_req0_next: got %0b want 1", bus.req0_ready); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        set_req0('{addr: 5'd4, data: 32'h0000_0044});
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_errors++; $display("FAIL areset_pre_ready0: got %0b want 1", bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        n_checks++;
        if ({bus.we3, bus.a3} !== {1'b1, 5'd4}) begin
            n_errors++; $display("FAIL areset_pre_write: we3=%0b a3=%0d want 1 4", bus.we3, bus.a3);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.we3, bus.a3, bus.wd3} !== 38'd0) begin
            n_errors++; $display("FAIL areset_immediate: we3=%0b a3=%0d wd3=%h want 0 0 0", bus.we3, bus.a3, bus.wd3);
        end
        tick();
        rst_n = 1'b1;
        set_req0('{addr: 5'd10, data: 32'h0000_00AA});
        set_req1('{addr: 5'd11, data: 32'h0000_00BB});
        #1;
        n_checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            n_errors++; $display("FAIL areset_first_tie: ready1/0=%b want 01", {bus.req1_ready, bus.req0_ready});
        end
        tick();
        idle_inputs();
        n_checks++;
        if ({bus.we3, bus.a3, bus.wd3} !== {1'b1, 5'd10, 32'hAA}) begin
            n_errors++; $display("FAIL areset_after_write: we3=%0b a3=%0d wd3=%h want 1 10 000000aa", bus.we3, bus.a3, bus.wd3);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_x0_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single synchronous write port (we3/a3/wd3) between two writeback requesters:
  - req0: the ALU/main pipeline writeback.
  - req1: the load / long-latency unit writeback.
- Arbitration is round-robin with valid/ready handshakes.
- The granted write is registered one cycle before it drives the register file.
- Busy flags for two read addresses let the hazard logic stall or forward against the write in flight.

Parameters:
- ADDRESS_WIDTH, 5, register index width.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  pipeline freeze; no grants while high
- req0_valid  input  1  requester 0 has a write
- req0_addr  input  ADDRESS_WIDTH  requester 0 destination register
- req0_data  input  DATA_WIDTH  requester 0 write data
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid  input  1  requester 1 has a write
- req1_addr  input  ADDRESS_WIDTH  requester 1 destination register
- req1_data  input  DATA_WIDTH  requester 1 write data
- req1_ready  output  1  requester 1 accepted this cycle
- we3  output  1  register file write enable
- a3  output  ADDRESS_WIDTH  register file write address
- wd3  output  DATA_WIDTH  register file write data
- q_a1  input  ADDRESS_WIDTH  hazard query address 1
- q_a2  input  ADDRESS_WIDTH  hazard query address 2
- busy1  output  1  q_a1 matches the write in flight
- busy2  output  1  q_a2 matches the write in flight

Behaviour:
- Reset (async, rst_n=0):
  - we3=0, a3=0, wd3=0, last_grant=1, so req0 wins the first tie.
  - Any registered write not yet committed is discarded, including on reset mid-operation.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - valid must not depend on ready.
  - Once valid is high, addr and data stay stable until the transfer.
- Grant logic (combinational; ready outputs are functions of the valids, hold and last_grant):
  - hold=1: both ready=0.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester other than last_grant gets ready=1.
  - Never both ready in the same cycle.
- last_grant updates to the granted index on every transfer. It is unchanged in cycles with no transfer.
- Output stage:
  - The register file always accepts, so the output register drains every cycle and one transfer can be taken per cycle, back-to-back.
  - On a transfer with addr != 0: next cycle we3=1, a3=addr, wd3=data.
  - On a transfer with addr == 0: accepted (ready=1) but next cycle we3=0; a3/wd3 are don't-care.
  - No transfer: next cycle we3=0; a3/wd3 hold their previous values.
- Latency: exactly 1 cycle from handshake edge to we3 pulse. The register file commits on the following edge.
- hold does not cancel a write already registered; it commits normally.
- Busy flags:
  - busy1 = we3 && (q_a1 == a3); same for busy2 with q_a2.
  - Purely combinational; zero when we3=0.
  - x0 is never busy, since we3 is never 1 with a3=0.
- Fairness: a requester held valid with hold=0 is granted within 2 cycles.
- Starvation-free under continuous contention: grants alternate 0,1,0,1…

Decomposition:
- Shared package rf_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32.
  - REG_ZERO constant (address 0).
  - Typedef wb_req_t {addr, data}.
  - Enum grant_e {GRANT_REQ0=0, GRANT_REQ1=1}.
- One natural sub-module: rr_arbiter2, a 2-way round-robin arbiter with its last_grant register, async active-low reset, valid inputs, one-hot grant outputs and an advance input.
- The top level adds the output register and busy comparators.

Test Plan:
- Reset and idle: rst_n=0 then release, both valid=0 → we3=0, a3=0, wd3=0, busy1=busy2=0 on every cycle.
- Single requester: req0 valid addr=5, data=0xDEADBEEF at edge N → req0_ready=1 in cycle N; we3=1, a3=5, wd3=0xDEADBEEF in cycle N+1; with q_a1=5, busy1=1 in cycle N+1 only.
- Contention, both held valid for 4 cycles from reset (req0 addr=1, req1 addr=2):
  - Grants go 0,1,0,1; we3 writes a3=1,2,1,2 one cycle later.
  - Never both ready in the same cycle.
- x0 and hold:
  - req1 valid addr=0, data=0x1234 → ready=1, we3=0 next cycle.
  - hold=1 with both valid → no ready, while a previously registered write still asserts we3 once.
- Async reset mid-operation: transfer at edge N, rst_n asserted low mid-cycle before edge N+1 → we3, a3 and wd3 drop to 0 immediately without a clock edge; the write never commits; the first tie after release grants req0.
